// File: rtl/uart_tx.sv
// uart_tx: parameterised UART transmitter (start, data LSB first, optional parity, 1-2 stop bits)
module uart_tx #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 sys_clk,
    input  logic                 reset,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
    state_t               state, state_n;
    logic [CW-1:0]        cnt, cnt_n;
    logic [2:0]           idx, idx_n;
    logic [DATA_BITS-1:0] shift, shift_n;
    logic                 par, par_n;
    logic                 tx_q, tx_n;
    logic                 last;
    assign tx_ready = state == S_IDLE;
    assign busy     = state != S_IDLE;
    assign tx       = tx_q;
    assign last     = cnt == '0;
    // next-state and datapath: each bit boundary reloads the bit timer and sets the next line level
    always_comb begin
        state_n = state;
        cnt_n   = (state != S_IDLE && !last) ? cnt - CW'(1) : cnt;
        idx_n   = idx;
        shift_n = shift;
        par_n   = par;
        tx_n    = tx_q;
        case (state)
            S_IDLE: if (tx_valid) begin
                state_n = S_START;
                tx_n    = 1'b0;
                cnt_n   = RELOAD;
                idx_n   = '0;
                shift_n = tx_data;
                par_n   = (^tx_data) ^ (PARITY == 2);
            end
            S_START: if (last) begin
                state_n = S_DATA;
                tx_n    = shift[0];
                cnt_n   = RELOAD;
                idx_n   = '0;
            end
            S_DATA: if (last) begin
                cnt_n = RELOAD;
                if (idx == 3'(DATA_BITS - 1)) begin
                    state_n = (PARITY != 0) ? S_PARITY : S_STOP;
                    tx_n    = (PARITY != 0) ? par : 1'b1;
                    idx_n   = '0;
                end else begin
                    idx_n   = idx + 3'd1;
                    shift_n = shift >> 1;
                    tx_n    = shift[1];
                end
            end
            S_PARITY: if (last) begin
                state_n = S_STOP;
                tx_n    = 1'b1;
                cnt_n   = RELOAD;
                idx_n   = '0;
            end
            S_STOP: if (last) begin
                if (idx == 3'(STOP_BITS - 1)) begin
                    state_n = S_IDLE;
                    idx_n   = '0;
                end else begin
                    idx_n = idx + 3'd1;
                    cnt_n = RELOAD;
                end
            end
            default: begin
                state_n = S_IDLE;
                tx_n    = 1'b1;
            end
        endcase
    end
    // state register; reset aborts any frame and parks the line high
    always_ff @(posedge sys_clk) begin
        if (reset) begin
            state <= S_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
            par   <= 1'b0;
            tx_q  <= 1'b1;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
            shift <= shift_n;
            par   <= par_n;
            tx_q  <= tx_n;
        end
    end
endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, meaning sys_clk cycles per bit period (legal range 2..65535).
REQ-002 SHALL have parameter DATA_BITS, default 8, meaning data bits per frame (legal range 5..8).
REQ-003 SHALL have parameter PARITY, default 0, meaning 0 = none, 1 = even, 2 = odd.
REQ-004 SHALL have parameter STOP_BITS, default 1, meaning stop bit count (1 or 2).
REQ-005 sys_clk  input  1  sole clock; all logic on rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 tx_data  input  DATA_BITS  byte to send; sampled only on accept.
REQ-008 tx_valid  input  1  upstream offers tx_data.
REQ-009 tx_ready  output  1  block can accept; high only in IDLE.
REQ-010 tx  output  1  serial line; idle high.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 SHALL use a registered FSM with states IDLE, START, DATA, PARITY, STOP.
REQ-013 Accept SHALL occur on a cycle where tx_valid && tx_ready; tx_data is latched into a shift register on that edge.
REQ-014 The FSM SHALL enter START on the edge after accept; tx goes low in that same cycle (1-cycle latency); tx is registered, with no combinational path from inputs.
REQ-015 Each bit SHALL last exactly CLKS_PER_BIT cycles, timed by a down-counter reloaded to CLKS_PER_BIT-1 at every bit boundary.
REQ-016 DATA SHALL transmit DATA_BITS bits LSB first, tracked by a bit index 0..DATA_BITS-1.
REQ-017 PARITY SHALL be entered only when PARITY != 0: even sends XOR of the data bits, odd sends its inverse; PARITY = 0 goes DATA -> STOP.
REQ-018 STOP SHALL drive tx high for STOP_BITS*CLKS_PER_BIT cycles, then return to IDLE.
REQ-019 Frame length SHALL be (1+DATA_BITS+(PARITY!=0)+STOP_BITS)*CLKS_PER_BIT cycles, counted from first low cycle to last stop cycle.
REQ-020 tx_ready SHALL be 0 from the accept edge until IDLE is re-entered; tx_valid asserted mid-frame is held off, not dropped or queued.
REQ-021 Back-to-back: with tx_valid held high, the next accept SHALL happen in the first IDLE cycle, giving exactly one idle-high cycle between the last stop cycle and the next start bit.
REQ-022 Changes to tx_data after accept SHALL NOT affect the frame in flight.
REQ-023 tx_valid deasserted without accept SHALL leave all state unchanged.

Reset
REQ-024 reset high SHALL force state = IDLE, tx = 1, tx_ready = 1 after the first clock following reset assertion, with busy = 0 and counters and shift register = 0.
REQ-025 reset asserted mid-frame SHALL abort the frame, return tx high on the next edge, and emit no partial stop bits.
REQ-026 tx_valid SHALL be ignored while reset is high; the first accept is possible on the first edge with reset low.
REQ-027 reset SHALL take priority over any simultaneous accept.

Verification (CLKS_PER_BIT=4, DATA_BITS=8, STOP_BITS=1 unless stated)
REQ-028 PARITY=0, send 0xA5 -> tx = 0 for 4 cycles, then 1,0,1,0,0,1,0,1 for 4 cycles each, then 1 for 4 cycles; 40-cycle frame; tx_ready low for the whole frame.
REQ-029 PARITY=1 with 0x07, then PARITY=2 with 0x07 -> parity bit = 1 for even, 0 for odd; 44-cycle frame.
REQ-030 tx_valid held high with 0x00 then 0xFF -> both frames correct, with exactly one idle cycle between them; the second byte is latched only at its own accept.
REQ-031 reset pulsed at cycle 13 of a 0x55 frame -> tx = 1 on the next edge; tx_ready = 1; the next frame sent afterwards is correct.
REQ-032 STOP_BITS=2, CLKS_PER_BIT=2, send 0x3C -> stop high for 4 cycles; frame = 22 cycles.
REQ-033 A loopback bench SHALL feed tx into the existing uart_rx with sys_clk = 20 ns and CLKS_PER_BIT matched; 16 random bytes SHALL be received equal to those sent.
